kc705_ethernet_rx_cmd_parser: RTL and testbench

KC705_ETHERNET_RX_CMD_PARSER -- requirements
Module: kc705_ethernet_rx_cmd_parser

---
 rtl/kc705_eth_cmd_pkg.sv | 30 +++
 rtl/kc705_eth_cmd_field_shift.sv | 45 ++++
 rtl/kc705_ethernet_rx_cmd_parser.sv | 181 ++++++++++++++++++
 tb/tb_kc705_ethernet_rx_cmd_parser.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kc705_eth_cmd_pkg.sv
// Shared definitions for the KC705 Ethernet RX command parser:
// FSM state encoding, default magic byte, record geometry and opcodes.
package kc705_eth_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIELDS  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } cmd_state_t;

  localparam logic [7:0] CMD_MAGIC_DEFAULT = 8'hA5;
  localparam int         CMD_BYTES_DEFAULT = 8;

  localparam logic [7:0] OPC_WRITE   = 8'h01;
  localparam logic [7:0] OPC_READ    = 8'h02;
  localparam logic [7:0] OPC_TRIGGER = 8'h03;

  // Bytes 1..7 of a record: opcode, addr (big-endian), data (big-endian).
  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_fields_t;

  function automatic cmd_fields_t unpack_fields(input logic [55:0] rec);
    return cmd_fields_t'(rec);
  endfunction

endpackage

// File: rtl/kc705_eth_cmd_field_shift.sv
// Seven-byte shift/capture register for the payload bytes of a command
// record, plus the 3-bit byte index. Bytes enter at the LSB end so that
// after the seventh shift the register holds opcode|addr|data MSB first.
// The register only moves when the parser shifts, so it stays frozen
// while a completed command is waiting for its handshake.
module kc705_eth_cmd_field_shift (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_shift,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  output logic [2:0]  o_index,
  output logic [55:0] o_fields
);

  logic [2:0]  r_index;
  logic [55:0] r_fields;

  // Byte index: 1 after the magic byte, +1 per payload byte (7 wraps to 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= 3'd0;
    end else if (i_clear) begin
      r_index <= 3'd0;
    end else if (i_start) begin
      r_index <= 3'd1;
    end else if (i_shift) begin
      r_index <= r_index + 3'd1;
    end
  end

  // Payload shift register; shifts in one byte per accepted payload byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fields <= '0;
    end else if (i_shift) begin
      r_fields <= {r_fields[47:0], i_byte};
    end
  end

  assign o_index  = r_index;
  assign o_fields = r_fields;

endmodule

// File: rtl/kc705_ethernet_rx_cmd_parser.sv
// KC705 Ethernet RX command parser: turns a byte stream from the RX
// decoder into fixed 8-byte command records (magic, opcode, addr, data)
// with a valid/ready handshake, plus single-cycle error pulses.
// Optional build macro KC705_CMD_PARSER_STATS_EN adds 16-bit wrapping
// counters of completed commands and error pulses.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | waiting for the magic byte of a new record
//   ST_FIELDS  | collecting record bytes 1..7 (index counts them)
//   ST_HOLD    | cmd_valid high, input stalled until cmd_ready
//   ST_DISCARD | dropping bytes up to and including tlast
module kc705_ethernet_rx_cmd_parser
  import kc705_eth_cmd_pkg::*;
#(
  parameter logic [7:0] CMD_MAGIC = CMD_MAGIC_DEFAULT,
  parameter int         CMD_BYTES = CMD_BYTES_DEFAULT
) (
  input  logic        axi_tclk,
  input  logic        axi_tresetn,
  input  logic        enable_cmd_parse,
  input  logic [7:0]  tdata,
  input  logic        tvalid,
  input  logic        tlast,
  output logic        tready,
  output logic [7:0]  cmd_opcode,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        err_magic,
  output logic        err_short
`ifdef KC705_CMD_PARSER_STATS_EN
  ,
  output logic [15:0] stat_cmd_count,
  output logic [15:0] stat_err_count
`endif
);

  // Index of the final payload byte (record length is fixed at 8).
  localparam logic [2:0] LP_IDX_LAST = 3'(CMD_BYTES - 1);

  cmd_state_t  r_state;
  logic        r_cmd_valid;
  logic        r_err_magic;
  logic        r_err_short;

  logic        w_accept;
  logic        w_is_magic;
  logic        w_last_idx;
  logic        w_start;
  logic        w_shift;
  logic        w_clear;
  logic [2:0]  w_index;
  logic [55:0] w_fields;
  cmd_fields_t w_cmd;

  // tready depends on state only, so the upstream decoder never sees a
  // combinational path from its own tvalid.
  assign tready     = (r_state != ST_HOLD);
  assign w_accept   = tvalid & tready;
  assign w_is_magic = (tdata == CMD_MAGIC);
  assign w_last_idx = (w_index == LP_IDX_LAST);

  // Strobes for the field register, mirroring the FSM transitions below.
  always_comb begin
    w_start = 1'b0;
    w_shift = 1'b0;
    w_clear = 1'b0;
    if (w_accept) begin
      if (r_state == ST_IDLE) begin
        w_start = enable_cmd_parse & w_is_magic & ~tlast;
      end else if (r_state == ST_FIELDS) begin
        w_shift = enable_cmd_parse & (w_last_idx | ~tlast);
        w_clear = ~enable_cmd_parse | (tlast & ~w_last_idx);
      end
    end
  end

  kc705_eth_cmd_field_shift u_field_shift (
    .clk      (axi_tclk),
    .rst_n    (axi_tresetn),
    .i_start  (w_start),
    .i_shift  (w_shift),
    .i_clear  (w_clear),
    .i_byte   (tdata),
    .o_index  (w_index),
    .o_fields (w_fields)
  );

  // Record sequencing FSM with registered cmd_valid and error pulses.
  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_err_magic <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      r_err_magic <= 1'b0;
      r_err_short <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!enable_cmd_parse) begin
              r_state <= tlast ? ST_IDLE : ST_DISCARD;
            end else if (w_is_magic) begin
              if (tlast) begin
                r_err_short <= 1'b1;
              end else begin
                r_state <= ST_FIELDS;
              end
            end else begin
              r_err_magic <= 1'b1;
              r_state     <= tlast ? ST_IDLE : ST_DISCARD;
            end
          end
        end
        ST_FIELDS: begin
          if (w_accept) begin
            if (!enable_cmd_parse) begin
              r_state <= tlast ? ST_IDLE : ST_DISCARD;
            end else if (w_last_idx) begin
              // tlast on the final byte simply ends the frame here.
              r_state     <= ST_HOLD;
              r_cmd_valid <= 1'b1;
            end else if (tlast) begin
              r_err_short <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (w_accept && tlast) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_cmd      = unpack_fields(w_fields);
  assign cmd_opcode = w_cmd.opcode;
  assign cmd_addr   = w_cmd.addr;
  assign cmd_data   = w_cmd.data;
  assign cmd_valid  = r_cmd_valid;
  assign err_magic  = r_err_magic;
  assign err_short  = r_err_short;

`ifdef KC705_CMD_PARSER_STATS_EN
  logic [15:0] r_stat_cmd_count;
  logic [15:0] r_stat_err_count;

  // Free-running wrap-around counters of handshakes and error pulses.
  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      r_stat_cmd_count <= 16'd0;
      r_stat_err_count <= 16'd0;
    end else begin
      if (r_cmd_valid && cmd_ready) begin
        r_stat_cmd_count <= r_stat_cmd_count + 16'd1;
      end
      if (r_err_magic || r_err_short) begin
        r_stat_err_count <= r_stat_err_count + 16'd1;
      end
    end
  end

  assign stat_cmd_count = r_stat_cmd_count;
  assign stat_err_count = r_stat_err_count;
`endif

endmodule

// File: tb/tb_kc705_ethernet_rx_cmd_parser.sv
// Directed bench for kc705_ethernet_rx_cmd_parser. Build with
// KC705_CMD_PARSER_STATS_EN defined to also exercise the stat counters.
module tb_kc705_ethernet_rx_cmd_parser;

  logic        axi_tclk;
  logic        axi_tresetn;
  logic        enable_cmd_parse;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        err_magic;
  logic        err_short;
`ifdef KC705_CMD_PARSER_STATS_EN
  logic [15:0] stat_cmd_count;
  logic [15:0] stat_err_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int          n_cmd   = 0;
  int          n_magic = 0;
  int          n_short = 0;
  bit          both_seen = 1'b0;
  logic [55:0] got_cmd [0:31];

  kc705_ethernet_rx_cmd_parser dut (
    .axi_tclk         (axi_tclk),
    .axi_tresetn      (axi_tresetn),
    .enable_cmd_parse (enable_cmd_parse),
    .tdata            (tdata),
    .tvalid           (tvalid),
    .tlast            (tlast),
    .tready           (tready),
    .cmd_opcode       (cmd_opcode),
    .cmd_addr         (cmd_addr),
    .cmd_data         (cmd_data),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .err_magic        (err_magic),
    .err_short        (err_short)
`ifdef KC705_CMD_PARSER_STATS_EN
    ,
    .stat_cmd_count   (stat_cmd_count),
    .stat_err_count   (stat_err_count)
`endif
  );

  initial axi_tclk = 1'b0;
  always #5 axi_tclk = ~axi_tclk;

  // Record every handshake and count error pulses as the DUT sees them.
  always @(posedge axi_tclk) begin
    if (cmd_valid && cmd_ready) begin
      if (n_cmd < 32) got_cmd[n_cmd] <= {cmd_opcode, cmd_addr, cmd_data};
      n_cmd <= n_cmd + 1;
    end
    if (err_magic) n_magic <= n_magic + 1;
    if (err_short) n_short <= n_short + 1;
    if (err_magic && err_short) both_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge axi_tclk);
    #1;
  endtask

  // Present one byte and hold it until the DUT accepts it.
  task automatic send_byte(input logic [7:0] d, input bit last);
    int n = 0;
    tdata  = d;
    tlast  = last;
    tvalid = 1'b1;
    while (!tready && n < 200) begin
      @(negedge axi_tclk);
      n++;
    end
    if (n >= 200) check("tready_timeout", tready, 1);
    @(posedge axi_tclk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_rec(input logic [63:0] rec, input bit last);
    for (int i = 7; i >= 0; i--) send_byte(rec[i*8 +: 8], last && (i == 0));
  endtask

  initial begin
    int base;
    int bm;
    int bs;
    int lowcnt;

    axi_tresetn      = 1'b0;
    enable_cmd_parse = 1'b1;
    tdata            = 8'h00;
    tvalid           = 1'b0;
    tlast            = 1'b0;
    cmd_ready        = 1'b0;
    tick(3);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_opcode", cmd_opcode, 0);
    check("rst_addr", cmd_addr, 0);
    check("rst_data", cmd_data, 0);
    check("rst_err_magic", err_magic, 0);
    check("rst_err_short", err_short, 0);
    axi_tresetn = 1'b1;
    tick(1);
    check("rst_tready", tready, 1);

    // Single good record, 1-cycle latency after the last byte.
    cmd_ready = 1'b1;
    base = n_cmd;
    send_rec(64'hA5_01_0010_DEADBEEF, 1'b1);
    check("latency_valid", cmd_valid, 1);
    check("hold_tready", tready, 0);
    tick(3);
    check("rec1_count", n_cmd - base, 1);
    check("rec1_fields", got_cmd[base], 56'h01_0010_DEADBEEF);
    check("rec1_valid_low", cmd_valid, 0);

    // Two back-to-back records, consumer stalls for 10 cycles.
    cmd_ready = 1'b0;
    base = n_cmd;
    lowcnt = 0;
    fork
      begin
        send_rec(64'hA5_02_1234_11223344, 1'b0);
        send_rec(64'hA5_03_ABCD_55667788, 1'b1);
      end
      begin
        int w = 0;
        while (!cmd_valid && w < 200) begin
          @(negedge axi_tclk);
          w++;
        end
        check("b2b_hold_seen", cmd_valid, 1);
        repeat (10) begin
          @(negedge axi_tclk);
          if (!tready) lowcnt++;
        end
        check("b2b_hold_opcode", cmd_opcode, 8'h02);
        check("b2b_hold_data", cmd_data, 32'h11223344);
        cmd_ready = 1'b1;
      end
    join
    tick(3);
    check("b2b_tready_low", lowcnt, 10);
    check("b2b_count", n_cmd - base, 2);
    check("b2b_first", got_cmd[base], 56'h02_1234_11223344);
    check("b2b_second", got_cmd[base + 1], 56'h03_ABCD_55667788);

    // Bad magic on a 10-byte frame.
    base = n_cmd; bm = n_magic; bs = n_short;
    for (int i = 0; i < 10; i++) send_byte((i == 0) ? 8'h5A : 8'(i), i == 9);
    tick(3);
    check("badmagic_err", n_magic - bm, 1);
    check("badmagic_short", n_short - bs, 0);
    check("badmagic_cmd", n_cmd - base, 0);
    check("badmagic_idle", tready, 1);

    // Short record then a good one.
    base = n_cmd; bm = n_magic; bs = n_short;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b1);
    tick(3);
    check("short_err", n_short - bs, 1);
    check("short_magic", n_magic - bm, 0);
    check("short_cmd", n_cmd - base, 0);
    send_rec(64'hA5_01_CAFE_01020304, 1'b1);
    tick(3);
    check("after_short_cmd", got_cmd[base], 56'h01_CAFE_01020304);

    // Parsing disabled for a whole record, then dropped mid-record.
    base = n_cmd; bm = n_magic; bs = n_short;
    enable_cmd_parse = 1'b0;
    send_rec(64'hA5_01_0010_DEADBEEF, 1'b1);
    send_byte(8'h77, 1'b1);
    enable_cmd_parse = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    enable_cmd_parse = 1'b0;
    send_byte(8'h00, 1'b0);
    enable_cmd_parse = 1'b1;
    send_byte(8'h10, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    tick(3);
    check("disable_cmd", n_cmd - base, 0);
    check("disable_magic", n_magic - bm, 0);
    check("disable_short", n_short - bs, 0);

    // Magic byte alone with tlast, then a lone non-magic byte with tlast.
    bm = n_magic; bs = n_short;
    send_byte(8'hA5, 1'b1);
    tick(2);
    check("magic_last_short", n_short - bs, 1);
    check("magic_last_magic", n_magic - bm, 0);
    send_byte(8'h3C, 1'b1);
    tick(2);
    check("lone_bad_magic", n_magic - bm, 1);
    base = n_cmd;
    send_rec(64'hA5_02_0004_0000AAAA, 1'b1);
    tick(3);
    check("after_lone_cmd", got_cmd[base], 56'h02_0004_0000AAAA);

    // Reset in the middle of a record.
    base = n_cmd;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'hDE, 1'b0);
    axi_tresetn = 1'b0;
    tick(2);
    check("midrst_valid", cmd_valid, 0);
    check("midrst_opcode", cmd_opcode, 0);
    check("midrst_addr", cmd_addr, 0);
    check("midrst_data", cmd_data, 0);
    axi_tresetn = 1'b1;
    tick(3);
    check("midrst_no_cmd", n_cmd - base, 0);
    check("midrst_tready", tready, 1);
    send_rec(64'hA5_03_0020_00000001, 1'b1);
    tick(3);
    check("midrst_next_cmd", got_cmd[base], 56'h03_0020_00000001);

`ifdef KC705_CMD_PARSER_STATS_EN
    axi_tresetn = 1'b0;
    tick(2);
    axi_tresetn = 1'b1;
    tick(1);
    check("stat_rst_cmd", stat_cmd_count, 0);
    check("stat_rst_err", stat_err_count, 0);
    send_rec(64'hA5_01_0001_00000011, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_rec(64'hA5_02_0002_00000022, 1'b0);
    send_byte(8'hA5, 1'b1);
    send_rec(64'hA5_03_0003_00000033, 1'b1);
    tick(3);
    check("stat_cmd", stat_cmd_count, 3);
    check("stat_err", stat_err_count, 2);
`endif

    check("err_exclusive", both_seen, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
